// File: rtl/mips_pkg.sv
// Shared MIPS core types: fetch entry layout, PC stepping and reset address.
// Pure declarations, no logic; imported by the fetch front end.
// No handshake of its own.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Byte addresses are word-aligned by discarding the two low bits.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries between PC generation and decode.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is accepted when not full or when popping in the same cycle; flush beats both.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_dat;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads imem combinationally, queues {pc,instr} to decode.
// Latency: instruction at PC X is on out_* one cycle after the edge where imem_a addresses X.
// Backpressure: fetch stalls (PC holds) while the queue is full and not popping; optional IFETCH_BOUND_CHECK_EN.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          ADDR_W     = 6,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_a,
  input  logic [31:0]        imem_rd,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               fetch_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]  pc;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head;
  fetch_entry_t     push_dat;
  logic             pop;
  logic             fetch_try;
  logic             push;
  logic             halted;
  logic             unused_count;

  assign imem_a    = pc[ADDR_W+1:2];
  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign pop       = out_valid && out_ready;

  // A fetch may use the slot freed by a same-cycle pop; redirect suppresses it.
  assign fetch_try = !redirect_valid && (!fifo_full || pop) && !halted;

  assign push_dat.pc    = pc;
  assign push_dat.instr = imem_rd;

  assign unused_count = ^fifo_count;

`ifdef IFETCH_BOUND_CHECK_EN
  logic fault_q;
  logic out_of_range;

  assign out_of_range = |pc[PC_W-1:ADDR_W+2];
  assign push         = fetch_try && !out_of_range;
  assign halted       = fault_q;
  assign fetch_fault  = fault_q;

  always_ff @(posedge clk) begin
    if (reset || redirect_valid) fault_q <= 1'b0;
    else if (fetch_try && out_of_range) fault_q <= 1'b1;
  end
`else
  assign push        = fetch_try;
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)               pc <= word_align(RESET_PC);
    else if (redirect_valid) pc <= word_align(redirect_pc);
    else if (push)           pc <= pc + PC_STEP;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (head)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboarded bench for ifetch_unit: directed scenarios then randomized reset/redirect/ready traffic.
module tb_ifetch_unit;
  import mips_pkg::*;

  localparam int          DEPTH = 2;
  localparam int          AW    = 6;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] LIMIT = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_rd;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fetch_fault;

  logic [31:0]   mem [64];

  fetch_entry_t  exp_q [$];
  logic [31:0]   mpc;
  bit            mfault;
  bit            mvalid = 1'b0;
  bit            done = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC   (RPC),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  assign imem_rd = mem[imem_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of pending fetches plus a program counter.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      exp_q.delete();
      mpc    = {RPC[31:2], 2'b00};
      mfault = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        mpc    = {redirect_pc[31:2], 2'b00};
        mfault = 1'b0;
      end else if (!mfault && exp_q.size() < DEPTH) begin
`ifdef IFETCH_BOUND_CHECK_EN
        if (mpc >= LIMIT) begin
          mfault = 1'b1;
        end else begin
          exp_q.push_back('{pc: mpc, instr: mem[mpc[7:2]]});
          mpc = mpc + 32'd4;
        end
`else
        exp_q.push_back('{pc: mpc, instr: mem[mpc[7:2]]});
        mpc = mpc + 32'd4;
`endif
      end
    end
  end

  // Monitor: compares visible outputs against the expected queue head.
  always @(negedge clk) begin
    if (mvalid && !done) begin
      chk("imem_a", 32'(imem_a), 32'(mpc[7:2]));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
      end else begin
        chk("out_pc_idle", out_pc, 32'h0);
        chk("out_instr_idle", out_instr, 32'h0);
      end
      chk("fetch_fault", 32'(fetch_fault), 32'(mfault));
    end
  end

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      reset          = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2002_0005;
    mem[1] = 32'h2007_0003;
    mem[2] = 32'h2003_000c;
    mem[3] = 32'h00e2_2025;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

    // Streaming from reset.
    cyc(1, 0, 32'h0, 1, 2);
    cyc(0, 0, 32'h0, 1, 6);
    // Fill under backpressure, then drain.
    cyc(1, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 0, 4);
    cyc(0, 0, 32'h0, 1, 3);
    // Redirect while full.
    cyc(0, 0, 32'h0, 0, 3);
    cyc(0, 1, 32'h3C, 0, 1);
    cyc(0, 0, 32'h0, 1, 4);
    // Redirect with coincident pop, then redirect under reset.
    cyc(0, 1, 32'h20, 1, 1);
    cyc(0, 0, 32'h0, 1, 3);
    cyc(1, 1, 32'h80, 1, 1);
    cyc(0, 0, 32'h0, 1, 3);
    // Top-of-memory redirect: wrap or bound fault.
    cyc(0, 1, 32'hFC, 1, 1);
    cyc(0, 0, 32'h0, 1, 5);
    cyc(0, 1, 32'h0, 1, 1);
    cyc(0, 0, 32'h0, 1, 3);
    // Reset with two entries queued.
    cyc(0, 0, 32'h0, 0, 3);
    cyc(1, 0, 32'h0, 0, 1);
    cyc(0, 0, 32'h0, 1, 4);

    // Randomized traffic, including unaligned and far targets.
    for (int n = 0; n < 2000; n++) begin
      logic        r, rv, rdy;
      logic [31:0] t;
      r   = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       t = 32'h0000_00F0 | 32'($urandom_range(0, 15));
        default: t = 32'($urandom_range(0, 255));
      endcase
      cyc(r, rv, t, rdy, 1);
    end

    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
